led_scroller: RTL and testbench
===============================

// Module: led_scroller
// PURPOSE
// Column-oriented pattern store and horizontal scroller feeding the LED matrix driver.
// Holds up to DEPTH 4-bit columns, one bit per matrix row, and slides an 8-column window
// across them at a programmable rate. It assembles each new window serially into a shadow
// and commits it atomically to leds1..leds4/leds_pwm, so the scanning driver never shows a torn frame.
// PARAMETERS
// DEPTH     64         pattern columns stored (power of two)
// AW        6          address width, log2(DEPTH)
// STEP_DIV  1200000    clk12MHz cycles per scroll step while running (10 Hz)
// PORTS
// clk12MHz    in   1     system clock, 12 MHz
// rst_n       in   1     asynchronous active-low reset
// wr_en       in   1     pattern write strobe
// wr_addr     in   AW    pattern column address
// wr_data     in   4     column bits; bit r drives matrix row r+1
// length      in   AW+1  active pattern length in columns, 0..DEPTH
// run         in   1     level: scroll continuously
// step_now    in   1     pulse: advance one column (honoured only in IDLE)
// brightness  in   3     PWM level, latched into leds_pwm at commit
// leds1..4    out  8     row images to driver; bit k = window column k (bit0 = led1)
// leds_pwm    out  3     brightness to driver
// busy        out  1     high in LOAD or COMMIT
// wrap        out  1     one-cycle pulse when pos advances from length-1 to 0
// BEHAVIOUR
// - Reset (async, any state): leds1..4=0, leds_pwm=0, busy=0, wrap=0, pos=0, divider=0,
//   shadow=0, state=IDLE. Pattern memory is NOT cleared.
// - Memory: one write port; write takes effect at the clock edge. A read of the address
//   being written in the same cycle returns the old data.
// - len_q: length latched on every entry to LOAD; values >DEPTH clamp to DEPTH. If pos>=len_q
//   at latch, pos<=0.
// - States: IDLE, WAIT, LOAD, COMMIT.
//   IDLE: divider held at 0. run=1 -> LOAD (pos unchanged, shows current window).
//         step_now=1 (run=0) -> pos advance, then LOAD. Both: run wins, no advance.
//   WAIT: divider counts 0..STEP_DIV-1; tick at STEP_DIV-1 -> divider<=0, pos advance, LOAD.
//         run=0 -> IDLE immediately, divider cleared.
//   LOAD: 8 cycles, k=0..7; idx starts at pos, shadow column k <= mem[idx];
//         idx <= (idx+1==len_q) ? 0 : idx+1 (true modulo, valid for len_q<8).
//         run changes are ignored until COMMIT.
//   COMMIT: 1 cycle; leds1..4 <= shadow rows, leds_pwm <= brightness;
//           then WAIT if run=1, else IDLE.
// - pos advance: pos <= (pos+1>=len_q) ? 0 : pos+1; wrap pulses in that cycle iff pos was
//   len_q-1 (and len_q>0).
// - len_q==0: every shadow column loads as 0 (blank frame); pos stays 0; no wrap.
// - Latency: from the edge sampling tick/run/step_now, outputs update on the 10th edge;
//   they are otherwise static.
// - Outputs registered; no combinational path from inputs to leds*/leds_pwm.
// TESTING
// 1 Reset: rst_n low mid-LOAD -> all outputs 0 immediately; after release state IDLE, busy=0.
// 2 Write col0=4'b0001, cols1..7=0, length=8, step_now at IDLE -> pos=1 -> leds1=8'h80 after
//   10 edges, leds2..4=0.
// 3 length=3, cols {1,2,4}, run=1 from pos=0 -> leds1=8'h49, leds2=8'h92, leds3=8'h24, leds4=0.
// 4 length=10, run=1, STEP_DIV=4 (bench override): wrap pulses once every 10 steps, exactly
//   when pos goes 9->0.
// 5 length=0, run=1 -> every commit gives leds1..4=0, wrap never asserts.
// 6 wr_en to address under read during LOAD -> committed column shows old data; next step shows new.

Source files
------------

// File: rtl/led_scroller.sv
// Column pattern store plus 8-column horizontal scroller. Each window is gathered
// serially into a shadow over 8 cycles, then committed to the driver outputs in one edge.
module led_scroller #(
    parameter int DEPTH    = 64,
    parameter int AW       = 6,
    parameter int STEP_DIV = 1200000
) (
    input  logic          clk12MHz,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [3:0]    wr_data,
    input  logic [AW:0]   length,
    input  logic          run,
    input  logic          step_now,
    input  logic [2:0]    brightness,
    output logic [7:0]    leds1,
    output logic [7:0]    leds2,
    output logic [7:0]    leds3,
    output logic [7:0]    leds4,
    output logic [2:0]    leds_pwm,
    output logic          busy,
    output logic          wrap
);

    localparam int          DW      = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [DW-1:0] DIV_TC = DW'(STEP_DIV - 1);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_L   = (AW+1)'(1);

    typedef enum logic [1:0] {IDLE, WAIT, LOAD, COMMIT} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     pos_q, pos_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [AW:0]       len_q, len_d;
    logic [2:0]        k_q, k_d;
    logic [DW-1:0]     div_q, div_d;
    logic [3:0][7:0]   shadow_q, shadow_d;
    logic [3:0][7:0]   leds_q, leds_d;
    logic [2:0]        pwm_q, pwm_d;
    logic              busy_q, busy_d;
    logic              wrap_q, wrap_d;

    logic [3:0]        mem_q [DEPTH];

    logic [AW:0]       len_clamp;
    logic [AW-1:0]     base_pos;
    logic [AW:0]       base_inc;
    logic [AW-1:0]     adv_pos;
    logic              adv_wrap;
    logic [AW:0]       idx_inc;
    logic [AW-1:0]     idx_next;
    logic [3:0]        rd_data;
    logic              load_go;
    logic              load_adv;

    // Read is combinational from the registered array, so a same-cycle write is seen only next cycle.
    always_ff @(posedge clk12MHz) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
    end

    always_comb begin
        len_clamp = (length > DEPTH_L) ? DEPTH_L : length;
        base_pos  = ({1'b0, pos_q} >= len_clamp) ? '0 : pos_q;
        base_inc  = {1'b0, base_pos} + ONE_L;
        adv_pos   = (base_inc >= len_clamp) ? '0 : base_inc[AW-1:0];
        adv_wrap  = (len_clamp != '0) && ({1'b0, base_pos} == (len_clamp - ONE_L));
        idx_inc   = {1'b0, idx_q} + ONE_L;
        idx_next  = (idx_inc == len_q) ? '0 : idx_inc[AW-1:0];
        rd_data   = mem_q[idx_q];
    end

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        idx_d    = idx_q;
        len_d    = len_q;
        k_d      = k_q;
        div_d    = div_q;
        shadow_d = shadow_q;
        leds_d   = leds_q;
        pwm_d    = pwm_q;
        wrap_d   = 1'b0;
        load_go  = 1'b0;
        load_adv = 1'b0;

        case (state_q)
            IDLE: begin
                div_d = '0;
                if (run) begin
                    load_go = 1'b1;
                end else if (step_now) begin
                    load_go  = 1'b1;
                    load_adv = 1'b1;
                end
            end
            WAIT: begin
                if (!run) begin
                    state_d = IDLE;
                    div_d   = '0;
                end else if (div_q == DIV_TC) begin
                    div_d    = '0;
                    load_go  = 1'b1;
                    load_adv = 1'b1;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            LOAD: begin
                for (int r = 0; r < 4; r++) begin
                    shadow_d[r][k_q] = (len_q == '0) ? 1'b0 : rd_data[r];
                end
                idx_d = idx_next;
                k_d   = k_q + 3'd1;
                if (k_q == 3'd7) state_d = COMMIT;
            end
            COMMIT: begin
                leds_d  = shadow_q;
                pwm_d   = brightness;
                state_d = run ? WAIT : IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Length is latched first so the advance and the out-of-range fold both use the new length.
        if (load_go) begin
            len_d   = len_clamp;
            pos_d   = load_adv ? adv_pos : base_pos;
            idx_d   = load_adv ? adv_pos : base_pos;
            wrap_d  = load_adv && adv_wrap;
            k_d     = 3'd0;
            state_d = LOAD;
        end

        busy_d = (state_d == LOAD) || (state_d == COMMIT);
    end

    always_ff @(posedge clk12MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pos_q    <= '0;
            idx_q    <= '0;
            len_q    <= '0;
            k_q      <= '0;
            div_q    <= '0;
            shadow_q <= '0;
            leds_q   <= '0;
            pwm_q    <= '0;
            busy_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            k_q      <= k_d;
            div_q    <= div_d;
            shadow_q <= shadow_d;
            leds_q   <= leds_d;
            pwm_q    <= pwm_d;
            busy_q   <= busy_d;
            wrap_q   <= wrap_d;
        end
    end

    assign leds1    = leds_q[0];
    assign leds2    = leds_q[1];
    assign leds3    = leds_q[2];
    assign leds4    = leds_q[3];
    assign leds_pwm = pwm_q;
    assign busy     = busy_q;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_led_scroller.sv
// Directed bench for led_scroller: table of single-frame vectors plus hand sequences
// for blank length, read/write collision, reset mid-load and wrap timing.
module tb_led_scroller;

    logic       clk12MHz = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [5:0] wr_addr;
    logic [3:0] wr_data;
    logic [6:0] length;
    logic       run;
    logic       step_now;
    logic [2:0] brightness;
    logic [7:0] leds1, leds2, leds3, leds4;
    logic [2:0] leds_pwm;
    logic       busy;
    logic       wrap;

    int checks = 0;
    int errors = 0;

    led_scroller #(.DEPTH(64), .AW(6), .STEP_DIV(4)) dut (
        .clk12MHz  (clk12MHz),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .length    (length),
        .run       (run),
        .step_now  (step_now),
        .brightness(brightness),
        .leds1     (leds1),
        .leds2     (leds2),
        .leds3     (leds3),
        .leds4     (leds4),
        .leds_pwm  (leds_pwm),
        .busy      (busy),
        .wrap      (wrap)
    );

    always #5 clk12MHz = ~clk12MHz;

    typedef struct {
        logic [6:0]  len;
        logic [39:0] cols;
        logic        use_run;
        logic        use_step;
        logic [2:0]  bri;
        logic        e_wrap;
        logic [7:0]  e1, e2, e3, e4;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk12MHz);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic write_cols(input logic [39:0] cols);
        for (int i = 0; i < 10; i++) begin
            wr_en   = 1'b1;
            wr_addr = 6'(i);
            wr_data = cols[4*i +: 4];
            tick();
        end
        wr_en = 1'b0;
    endtask

    initial begin
        int rises, adv, wraps;
        logic busy_prev;

        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; length = '0;
        run = 1'b0; step_now = 1'b0; brightness = '0;

        vecs[0] = '{7'd8,   40'h0000000001, 1'b0, 1'b1, 3'd5, 1'b0, 8'h80, 8'h00, 8'h00, 8'h00};
        vecs[1] = '{7'd3,   40'h0000000421, 1'b1, 1'b0, 3'd3, 1'b0, 8'h49, 8'h92, 8'h24, 8'h00};
        vecs[2] = '{7'd3,   40'h0000000421, 1'b1, 1'b1, 3'd7, 1'b0, 8'h49, 8'h92, 8'h24, 8'h00};
        vecs[3] = '{7'd3,   40'h0000000421, 1'b0, 1'b1, 3'd1, 1'b0, 8'h24, 8'h49, 8'h92, 8'h00};
        vecs[4] = '{7'd10,  40'hA5C30F1248, 1'b0, 1'b1, 3'd6, 1'b0, 8'hAC, 8'h2A, 8'hC9, 8'h48};
        vecs[5] = '{7'd1,   40'h0000000005, 1'b0, 1'b1, 3'd2, 1'b1, 8'hFF, 8'h00, 8'hFF, 8'h00};
        vecs[6] = '{7'd100, 40'h0080000001, 1'b1, 1'b0, 3'd4, 1'b0, 8'h01, 8'h00, 8'h00, 8'h80};

        #12;
        rst_n = 1'b1;
        tick();
        chk("reset_leds1", {24'd0, leds1}, 32'h0);
        chk("reset_pwm",   {29'd0, leds_pwm}, 32'h0);
        chk("reset_busy",  {31'd0, busy}, 32'h0);
        chk("reset_wrap",  {31'd0, wrap}, 32'h0);

        foreach (vecs[v]) begin
            pulse_reset();
            write_cols(vecs[v].cols);
            length     = vecs[v].len;
            brightness = vecs[v].bri;
            run        = vecs[v].use_run;
            step_now   = vecs[v].use_step;
            tick();
            step_now = 1'b0;
            chk($sformatf("v%0d_wrap", v), {31'd0, wrap}, {31'd0, vecs[v].e_wrap});
            repeat (8) tick();
            chk($sformatf("v%0d_busy_commit", v), {31'd0, busy}, 32'h1);
            chk($sformatf("v%0d_leds1_early", v), {24'd0, leds1}, 32'h0);
            tick();
            chk($sformatf("v%0d_leds1", v), {24'd0, leds1}, {24'd0, vecs[v].e1});
            chk($sformatf("v%0d_leds2", v), {24'd0, leds2}, {24'd0, vecs[v].e2});
            chk($sformatf("v%0d_leds3", v), {24'd0, leds3}, {24'd0, vecs[v].e3});
            chk($sformatf("v%0d_leds4", v), {24'd0, leds4}, {24'd0, vecs[v].e4});
            chk($sformatf("v%0d_pwm", v),   {29'd0, leds_pwm}, {29'd0, vecs[v].bri});
            chk($sformatf("v%0d_busy_after", v), {31'd0, busy}, 32'h0);
            run = 1'b0;
            repeat (12) tick();
        end

        // Zero length blanks the frame (leds held 01/00/00/80 from the last vector) and never wraps.
        length = 7'd0;
        run    = 1'b1;
        repeat (10) tick();
        chk("len0_leds1", {24'd0, leds1}, 32'h0);
        chk("len0_leds4", {24'd0, leds4}, 32'h0);
        wraps = 0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (wrap) wraps++;
        end
        chk("len0_wraps", wraps, 0);
        chk("len0_leds_run", {leds1, leds2, leds3, leds4}, 32'h0);
        run = 1'b0;
        repeat (15) tick();

        // Write to the column being read in the first LOAD cycle.
        pulse_reset();
        write_cols(40'h0000000030);
        length   = 7'd8;
        step_now = 1'b1;
        tick();
        step_now = 1'b0;
        wr_en = 1'b1; wr_addr = 6'd1; wr_data = 4'hF;
        tick();
        wr_en = 1'b0;
        repeat (8) tick();
        chk("coll_old", {leds1, leds2, leds3, leds4}, 32'h01010000);
        step_now = 1'b1;
        tick();
        step_now = 1'b0;
        repeat (9) tick();
        chk("coll_new", {leds1, leds2, leds3, leds4}, 32'h80808080);

        // Asynchronous reset in the middle of a load.
        step_now = 1'b1;
        tick();
        step_now = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_leds", {leds1, leds2, leds3, leds4}, 32'h0);
        chk("rst_mid_busy", {31'd0, busy}, 32'h0);
        chk("rst_mid_pwm",  {29'd0, leds_pwm}, 32'h0);
        rst_n = 1'b1;
        tick();
        chk("rst_idle_busy", {31'd0, busy}, 32'h0);
        repeat (12) tick();
        chk("rst_idle_static", {leds1, 21'd0, busy, 2'd0}, 32'h0);

        // Wrap timing over a 10-column run: pulse exactly on every tenth advance.
        pulse_reset();
        write_cols(40'hA5C30F1248);
        length = 7'd10;
        run    = 1'b1;
        rises = 0; adv = 0; wraps = 0; busy_prev = 1'b0;
        for (int c = 0; c < 400; c++) begin
            logic exp_wrap;
            tick();
            exp_wrap = 1'b0;
            if (busy && !busy_prev) begin
                rises++;
                if (rises > 1) begin
                    adv++;
                    exp_wrap = (adv % 10 == 0);
                end
            end
            if (wrap) wraps++;
            if (wrap !== exp_wrap) begin
                chk($sformatf("wrap_cycle%0d_adv%0d", c, adv), {31'd0, wrap}, {31'd0, exp_wrap});
            end else if (exp_wrap) begin
                chk("wrap_pulse", {31'd0, wrap}, 32'h1);
            end
            busy_prev = busy;
        end
        chk("wrap_adv_enough", {31'd0, adv >= 20}, 32'h1);
        chk("wrap_count", wraps, adv / 10);
        run = 1'b0;
        repeat (15) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
